// File: rtl/chimp_pkg.sv
// chimp_pkg: shared constants and types for the chimp board loader.
//   NUM_CELLS_DEF : default number of board cells (8x5 grid)
//   ADDR_W/TILE_W : board address and tile value widths
//   LFSR_TAPS     : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   state_t       : loader FSM states; ST_CLEAR exists only when
//                   CHIMP_LOADER_CLEAR_EN is defined
package chimp_pkg;

    localparam int          NUM_CELLS_DEF = 40;
    localparam int          ADDR_W        = 6;
    localparam int          TILE_W        = 5;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
`ifdef CHIMP_LOADER_CLEAR_EN
        ST_CLEAR = 3'd1,
`endif
        ST_PICK  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/chimp_lfsr16.sv
// chimp_lfsr16: 16-bit maximal-length Galois LFSR, advances every cycle.
//   clk     : clock, state on rising edge
//   iResetn : asynchronous active-low reset, loads SEED
//   oLfsr   : current LFSR state (never zero for a non-zero SEED)
module chimp_lfsr16
    import chimp_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        iResetn,
    output logic [15:0] oLfsr
);

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            oLfsr <= SEED;
        end else begin
            oLfsr <= {1'b0, oLfsr[15:1]} ^ (oLfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/chimp_board_loader.sv
// chimp_board_loader: places tiles 1..level on random free board cells.
// Optional feature macro: CHIMP_LOADER_CLEAR_EN -- when defined, every load
// first writes 0 to every cell in ascending address order.
//
// Ports:
//   clk       : clock
//   iResetn   : asynchronous active-low reset
//   iStart    : load request, only honoured in IDLE
//   iLevel    : number of tiles to place, captured with iStart
//   iWrReady  : board memory accepts the presented write
//   oBusy     : high whenever the FSM is not in IDLE
//   oDone     : one-cycle pulse at load completion
//   oWrEn     : write request (valid)
//   oWrAddr   : cell index of the write
//   oWrData   : tile value (0 = empty cell)
//   oState    : current FSM state, for observation
//
// Write handshake: oWrEn is the valid; once raised, oWrAddr/oWrData stay
// constant until a cycle with iWrReady=1, and that cycle transfers the write.
module chimp_board_loader
    import chimp_pkg::*;
#(
    parameter int          NUM_CELLS = NUM_CELLS_DEF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iStart,
    input  logic [4:0] iLevel,
    input  logic       iWrReady,
    output logic       oBusy,
    output logic       oDone,
    output logic       oWrEn,
    output logic [5:0] oWrAddr,
    output logic [4:0] oWrData,
    output logic [2:0] oState
);

    state_t                state;
    state_t                state_nxt;
    logic   [15:0]         lfsr;
    logic   [NUM_CELLS-1:0] occupied;
    logic   [TILE_W-1:0]   level;
    logic   [TILE_W-1:0]   count;
    logic   [ADDR_W-1:0]   cand;
    logic                  cand_ok;
    logic                  last_tile;
    logic                  unused_lfsr_hi;

`ifdef CHIMP_LOADER_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);
`endif

    chimp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .iResetn (iResetn),
        .oLfsr   (lfsr)
    );

    // Only the low bits pick a cell; the rest just keep the sequence long.
    assign cand           = lfsr[ADDR_W-1:0];
    assign unused_lfsr_hi = ^lfsr[15:ADDR_W];

    // The range test guards the bitmap lookup for candidates past the board.
    assign cand_ok   = (int'(cand) < NUM_CELLS) && !occupied[cand];
    assign last_tile = ((count + 5'd1) == level);

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (iStart) begin
`ifdef CHIMP_LOADER_CLEAR_EN
                    state_nxt = ST_CLEAR;
`else
                    state_nxt = (iLevel == 5'd0) ? ST_DONE : ST_PICK;
`endif
                end
            end
`ifdef CHIMP_LOADER_CLEAR_EN
            ST_CLEAR: begin
                if (iWrReady && (oWrAddr == LAST_ADDR)) begin
                    state_nxt = (level == 5'd0) ? ST_DONE : ST_PICK;
                end
            end
`endif
            ST_PICK: begin
                if (cand_ok) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (iWrReady) begin
                    state_nxt = last_tile ? ST_DONE : ST_PICK;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: captured level, placed count, occupancy and write registers.
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            level    <= '0;
            count    <= '0;
            occupied <= '0;
            oWrAddr  <= '0;
            oWrData  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        level    <= iLevel;
                        count    <= '0;
                        occupied <= '0;
`ifdef CHIMP_LOADER_CLEAR_EN
                        oWrAddr  <= '0;
                        oWrData  <= '0;
`endif
                    end
                end
`ifdef CHIMP_LOADER_CLEAR_EN
                ST_CLEAR: begin
                    if (iWrReady && (oWrAddr != LAST_ADDR)) begin
                        oWrAddr <= oWrAddr + 6'd1;
                    end
                end
`endif
                ST_PICK: begin
                    if (cand_ok) begin
                        occupied[cand] <= 1'b1;
                        oWrAddr        <= cand;
                        oWrData        <= count + 5'd1;
                    end
                end
                ST_WRITE: begin
                    if (iWrReady) begin
                        count <= count + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CHIMP_LOADER_CLEAR_EN
    assign oWrEn = (state == ST_WRITE) || (state == ST_CLEAR);
`else
    assign oWrEn = (state == ST_WRITE);
`endif
    assign oBusy  = (state != ST_IDLE);
    assign oDone  = (state == ST_DONE);
    assign oState = state;

endmodule

// File: tb/tb_chimp_board_loader.sv
// tb_chimp_board_loader: self-checking bench for chimp_board_loader.
// Expected tile values are queued when a load starts and popped by the
// negedge monitor whenever a write transfers.
module tb_chimp_board_loader;

  localparam int NUM_CELLS = 40;
  localparam int BUDGET    = 5000;

  logic       clk;
  logic       iResetn;
  logic       iStart;
  logic [4:0] iLevel;
  logic       iWrReady;
  logic       oBusy;
  logic       oDone;
  logic       oWrEn;
  logic [5:0] oWrAddr;
  logic [4:0] oWrData;
  logic [2:0] oState;

  int n_pass = 0;
  int n_total = 0;

  logic [4:0]  exp_q[$];
  logic [63:0] seen;
  int tile_writes;
  int clear_cnt;
  int clear_exp_addr;
  int done_cnt;
  int cyc = 0;
  int done_cyc;
  int last_wr_cyc;
  int ready_mode = 0;
  bit hold_valid = 0;
  logic [5:0] hold_addr;
  logic [4:0] hold_data;

  chimp_board_loader dut (
    .clk      (clk),
    .iResetn  (iResetn),
    .iStart   (iStart),
    .iLevel   (iLevel),
    .iWrReady (iWrReady),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oWrEn    (oWrEn),
    .oWrAddr  (oWrAddr),
    .oWrData  (oWrData),
    .oState   (oState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ready driver: 0 = always ready, 1 = random 50%, 2 = stall on tile 3
  initial begin
    iWrReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       iWrReady = 1'b1;
        1:       iWrReady = ($urandom_range(0, 1) == 1);
        default: iWrReady = !(oWrEn && oWrData == 5'd3);
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!iResetn) begin
      hold_valid = 0;
    end else begin
      if (hold_valid) begin
        n_total++;
        if (oWrEn !== 1'b1 || oWrAddr !== hold_addr || oWrData !== hold_data)
          $display("FAIL hold_stable: got en=%0b addr=%0d data=%0d expected en=1 addr=%0d data=%0d",
                   oWrEn, oWrAddr, oWrData, hold_addr, hold_data);
        else n_pass++;
      end
      hold_valid = oWrEn && !iWrReady;
      hold_addr  = oWrAddr;
      hold_data  = oWrData;

      if (!oBusy || oDone) begin
        n_total++;
        if (oWrEn !== 1'b0) $display("FAIL wren_idle_done: got %0b expected 0", oWrEn);
        else n_pass++;
      end

      if (oDone) begin
        done_cnt++;
        done_cyc = cyc;
      end

      if (oWrEn && iWrReady) begin
        last_wr_cyc = cyc;
`ifdef CHIMP_LOADER_CLEAR_EN
        if (oWrData == 5'd0) begin
          n_total++;
          if (int'(oWrAddr) !== clear_exp_addr)
            $display("FAIL clear_addr: got %0d expected %0d", oWrAddr, clear_exp_addr);
          else n_pass++;
          clear_exp_addr++;
          clear_cnt++;
        end else
`endif
        begin
`ifdef CHIMP_LOADER_CLEAR_EN
          n_total++;
          if (clear_cnt !== NUM_CELLS)
            $display("FAIL clear_before_tile: got %0d expected %0d", clear_cnt, NUM_CELLS);
          else n_pass++;
`endif
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got data=%0d expected no write", oWrData);
          end else begin
            logic [4:0] exp_d;
            exp_d = exp_q.pop_front();
            if (oWrData !== exp_d) $display("FAIL tile_data: got %0d expected %0d", oWrData, exp_d);
            else n_pass++;
          end
          n_total++;
          if (int'(oWrAddr) >= NUM_CELLS || seen[oWrAddr])
            $display("FAIL tile_addr: got %0d expected unused cell < %0d", oWrAddr, NUM_CELLS);
          else n_pass++;
          seen[oWrAddr] = 1'b1;
          tile_writes++;
        end
      end
    end
  end

  // driver tasks
  task automatic start_load(input logic [4:0] lvl);
    exp_q.delete();
    seen           = '0;
    tile_writes    = 0;
    clear_cnt      = 0;
    clear_exp_addr = 0;
    done_cnt       = 0;
    done_cyc       = -1;
    last_wr_cyc    = -100;
    for (int i = 1; i <= int'(lvl); i++) exp_q.push_back(5'(i));
    @(posedge clk);
    #1;
    iStart = 1'b1;
    iLevel = lvl;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    iLevel = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (oDone) begin
        ok = 1;
        break;
      end
    end
  endtask

  // tests
  task automatic test_reset;
    iResetn = 1'b0;
    iStart  = 1'b0;
    iLevel  = 5'd0;
    repeat (3) @(negedge clk);
    n_total++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", oBusy); else n_pass++;
    n_total++; if (oDone !== 1'b0) $display("FAIL reset_done: got %0b expected 0", oDone); else n_pass++;
    n_total++; if (oWrEn !== 1'b0) $display("FAIL reset_wren: got %0b expected 0", oWrEn); else n_pass++;
    n_total++; if (oWrAddr !== 6'd0) $display("FAIL reset_addr: got %0d expected 0", oWrAddr); else n_pass++;
    n_total++; if (oWrData !== 5'd0) $display("FAIL reset_data: got %0d expected 0", oWrData); else n_pass++;
    @(posedge clk);
    #1;
    iResetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_level4;
    bit ok;
    ready_mode = 0;
    start_load(5'd4);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL l4_done_timeout: got none expected oDone"); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (oBusy !== 1'b0) $display("FAIL l4_busy_after: got %0b expected 0", oBusy); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (tile_writes !== 4) $display("FAIL l4_writes: got %0d expected 4", tile_writes); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL l4_queue: got %0d left expected 0", exp_q.size()); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL l4_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
    n_total++;
    if (done_cyc - last_wr_cyc !== 1) $display("FAIL l4_done_lat: got %0d expected 1", done_cyc - last_wr_cyc);
    else n_pass++;
  endtask

  task automatic test_level31_random_ready;
    bit ok;
    ready_mode = 1;
    start_load(5'd31);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL l31_done_timeout: got none expected oDone"); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (tile_writes !== 31) $display("FAIL l31_writes: got %0d expected 31", tile_writes); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL l31_queue: got %0d left expected 0", exp_q.size()); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL l31_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL l31_busy_after: got %0b expected 0", oBusy); else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_level0;
    bit ok;
    ready_mode = 0;
    start_load(5'd0);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL l0_done_timeout: got none expected oDone"); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (oBusy !== 1'b0) $display("FAIL l0_busy_after: got %0b expected 0", oBusy); else n_pass++;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (tile_writes !== 0) $display("FAIL l0_writes: got %0d expected 0", tile_writes); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL l0_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_restart_ignored;
    bit ok;
    ready_mode = 0;
    start_load(5'd5);
    repeat (3) @(posedge clk);
    #1;
    iStart = 1'b1;
    iLevel = 5'd9;
    @(posedge clk);
    #1;
    iStart = 1'b0;
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL rs_done_timeout: got none expected oDone"); else n_pass++;
    repeat (4) @(negedge clk);
    #1;
    n_total++; if (tile_writes !== 5) $display("FAIL rs_writes: got %0d expected 5", tile_writes); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL rs_queue: got %0d left expected 0", exp_q.size()); else n_pass++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL rs_busy_after: got %0b expected 0", oBusy); else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    bit ok;
    ready_mode = 2;
    start_load(5'd5);
    ok = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (oWrEn && oWrData == 5'd3) begin
        ok = 1;
        break;
      end
    end
    n_total++; if (!ok) $display("FAIL rw_tile3_timeout: got none expected write of tile 3"); else n_pass++;
    n_total++; if (tile_writes !== 2) $display("FAIL rw_pre_writes: got %0d expected 2", tile_writes); else n_pass++;
    #2;
    iResetn = 1'b0;
    #1;
    n_total++; if (oWrEn !== 1'b0) $display("FAIL rw_wren: got %0b expected 0", oWrEn); else n_pass++;
    n_total++; if (oBusy !== 1'b0) $display("FAIL rw_busy: got %0b expected 0", oBusy); else n_pass++;
    n_total++; if (oWrData !== 5'd0) $display("FAIL rw_data: got %0d expected 0", oWrData); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    iResetn = 1'b1;
    ready_mode = 0;
    start_load(5'd2);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL rw_done_timeout: got none expected oDone"); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (tile_writes !== 2) $display("FAIL rw_post_writes: got %0d expected 2", tile_writes); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL rw_queue: got %0d left expected 0", exp_q.size()); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL rw_done_cnt: got %0d expected 1", done_cnt); else n_pass++;
  endtask

`ifdef CHIMP_LOADER_CLEAR_EN
  task automatic test_clear;
    bit ok;
    ready_mode = 1;
    start_load(5'd1);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL cl_done_timeout: got none expected oDone"); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (clear_cnt !== NUM_CELLS) $display("FAIL cl_count: got %0d expected %0d", clear_cnt, NUM_CELLS); else n_pass++;
    n_total++; if (tile_writes !== 1) $display("FAIL cl_writes: got %0d expected 1", tile_writes); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL cl_queue: got %0d left expected 0", exp_q.size()); else n_pass++;
    ready_mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_level4();
    test_level31_random_ready();
    test_level0();
    test_restart_ignored();
    test_reset_mid_write();
`ifdef CHIMP_LOADER_CLEAR_EN
    test_clear();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/chimp_board_loader.md
CHIMP_BOARD_LOADER -- requirements
Module: chimp_board_loader

Interface
REQ-001 Parameter NUM_CELLS, default 40; number of grid cells (8x5 board), legal range 32..64.
REQ-002 Parameter LFSR_SEED, default 16'hACE1; non-zero LFSR reset value.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 iResetn  input  1  reset, asynchronous, active-low.
REQ-005 iStart  input  1  request to load a new board; sampled only in IDLE.
REQ-006 iLevel  input  5  tiles to place (0..31); captured on accepted iStart.
REQ-007 iWrReady  input  1  board memory accepts the presented write this cycle.
REQ-008 oBusy  output  1  high in every state except IDLE.
REQ-009 oDone  output  1  one-cycle pulse when the load completes.
REQ-010 oWrEn  output  1  write request to board memory.
REQ-011 oWrAddr  output  6  cell index 0..NUM_CELLS-1.
REQ-012 oWrData  output  5  tile number 1..31; 0 means empty cell.

Function
REQ-013 States SHALL be IDLE, CLEAR, PICK, WRITE, DONE.
REQ-014 IDLE: on iStart, capture iLevel, clear the occupancy bitmap, zero the placed count, go to CLEAR (macro on) or PICK (macro off).
REQ-015 iLevel==0 on start SHALL go directly to DONE with no tile writes (CLEAR pass still runs if compiled in).
REQ-016 The 16-bit maximal LFSR SHALL advance every cycle in all states, including IDLE.
REQ-017 PICK: candidate = LFSR[5:0]; if candidate >= NUM_CELLS or occupied, stay in PICK and retry next cycle; otherwise mark it occupied, latch oWrAddr=candidate and oWrData=count+1, go to WRITE.
REQ-018 WRITE: oWrEn held high with stable oWrAddr/oWrData until the cycle iWrReady=1; that cycle completes the write.
REQ-019 On write completion, count increments; if count+1==captured level go to DONE, else PICK.
REQ-020 DONE: oDone=1 for exactly one cycle, then IDLE; oBusy low the cycle after DONE.
REQ-021 iStart while oBusy=1 SHALL be ignored; iLevel changes after capture SHALL have no effect.
REQ-022 No cell SHALL be written with a non-zero value twice in one load; written values SHALL be exactly 1..level.
REQ-023 oWrEn SHALL be low in IDLE, PICK and DONE.

Reset
REQ-024 Asserting iResetn low at any time, including mid-WRITE, SHALL immediately force IDLE, LFSR=LFSR_SEED, bitmap and count zero, all outputs 0.
REQ-025 After reset release, the first accepted iStart SHALL behave as a fresh load.

Configuration
REQ-026 Macro CHIMP_LOADER_CLEAR_EN: when defined, CLEAR writes oWrData=0 to addresses 0..NUM_CELLS-1 in ascending order using the REQ-018 handshake, then enters PICK (or DONE for level 0).
REQ-027 Without CHIMP_LOADER_CLEAR_EN, the CLEAR state and its logic SHALL be absent; board clearing is the board memory's own responsibility.

Structure
REQ-028 Package chimp_pkg SHALL hold the state enum typedef, NUM_CELLS default, address/tile width constants and the LFSR tap constant.
REQ-029 LFSR SHALL be a sub-module chimp_lfsr16 (clk, iResetn, seed parameter, 16-bit output); all other logic in one module.

Verification
REQ-030 Level 4, iWrReady tied 1 -> exactly 4 tile writes, data 1,2,3,4 in order, 4 distinct addresses <40, oDone one cycle after the 4th write.
REQ-031 Level 31, iWrReady random 50% -> 31 distinct addresses, oWrAddr/oWrData stable while oWrEn high and iWrReady low, single oDone.
REQ-032 Level 0 -> no non-zero writes, oDone pulses, oBusy returns low.
REQ-033 iStart pulsed again mid-load with iLevel=9 -> ignored, load finishes with original level count.
REQ-034 iResetn low during WRITE of tile 3 -> oWrEn/oBusy 0 immediately; next start with level 2 yields exactly 2 writes.
REQ-035 With CHIMP_LOADER_CLEAR_EN defined, level 1 -> 40 zero writes to addresses 0..39, then one write of data 1.
